// File: rtl/scram_ctrl_pkt_gen.sv
// Scrambler control packet generator: host-staged PID/CW entries sent as 6-word packets,
// plus a PID-table clear sweep. Optional macro SCRAM_CLR_ON_RST_EN runs a sweep after reset.
module scram_ctrl_pkt_gen #(
  parameter int U_DLY     = 1,
  parameter int CLR_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wr,
  input  logic [2:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] sc_ctrl_pkt_d,
  output logic        sc_ctrl_pkt_dval,
  output logic        sc_ctrl_pkt_eof,
  output logic        scram_clr,
  output logic        busy,
  output logic        cmd_err,
  output logic [15:0] pkt_cnt
);

  localparam int CntW = (CLR_DEPTH > 8) ? $clog2(CLR_DEPTH) : 3;

  typedef enum logic [1:0] {StIdle, StSend, StClr} state_e;

  state_e          r_state;
  logic [5:0]      r_idx;
  logic [15:0]     r_stg [1:5];
  logic [15:0]     r_shd [0:5];
  logic [2:0]      r_wix;
  logic [CntW-1:0] r_clr_cnt;
  logic [15:0]     r_d;
  logic            r_dval;
  logic            r_eof;
  logic            r_clr;
  logic            r_busy;
  logic            r_cmd_err;
  logic [15:0]     r_pkt_cnt;

  logic w_cmd_wr, w_commit, w_clear, w_err_clr, w_auto, w_reject_all, w_err_set;
  logic w_unused_dly;

  assign w_unused_dly = (U_DLY != 0);

`ifdef SCRAM_CLR_ON_RST_EN
  logic r_auto_clr;
  assign w_auto = r_auto_clr;
`else
  assign w_auto = 1'b0;
`endif

  assign w_cmd_wr  = cpu_wr && (cpu_addr == 3'd6);
  assign w_commit  = w_cmd_wr && cpu_wdata[0];
  assign w_clear   = w_cmd_wr && cpu_wdata[1];
  assign w_err_clr = w_cmd_wr && cpu_wdata[2];
  // A pending post-reset sweep counts as busy for command acceptance.
  assign w_reject_all = (r_state != StIdle) || w_auto;
  assign w_err_set    = w_reject_all ? (w_commit || w_clear) : (w_commit && w_clear);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      for (int k = 1; k <= 5; k++) r_stg[k] <= '0;
    end else if (cpu_wr) begin
      case (cpu_addr)
        3'd0:                         r_idx <= cpu_wdata[5:0];
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5: r_stg[cpu_addr] <= cpu_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_wix     <= '0;
      r_clr_cnt <= '0;
      r_d       <= '0;
      r_dval    <= 1'b0;
      r_eof     <= 1'b0;
      r_clr     <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_pkt_cnt <= '0;
      for (int k = 0; k < 6; k++) r_shd[k] <= '0;
`ifdef SCRAM_CLR_ON_RST_EN
      r_auto_clr <= 1'b1;
`endif
    end else begin
      if (w_err_clr)      r_cmd_err <= 1'b0;
      else if (w_err_set) r_cmd_err <= 1'b1;

      case (r_state)
        StIdle: begin
          if (w_auto || w_clear) begin
            r_state   <= StClr;
            r_busy    <= 1'b1;
            r_clr     <= 1'b1;
            r_clr_cnt <= '0;
`ifdef SCRAM_CLR_ON_RST_EN
            r_auto_clr <= 1'b0;
`endif
          end else if (w_commit) begin
            r_shd[0] <= {10'b0, r_idx};
            for (int k = 1; k <= 5; k++) r_shd[k] <= r_stg[k];
            r_state <= StSend;
            r_busy  <= 1'b1;
            r_wix   <= '0;
            r_d     <= {10'b0, r_idx};
            r_dval  <= 1'b1;
            r_eof   <= 1'b0;
          end
        end
        StSend: begin
          if (r_wix == 3'd5) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_d       <= '0;
            r_dval    <= 1'b0;
            r_eof     <= 1'b0;
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end else begin
            r_wix <= r_wix + 3'd1;
            r_d   <= r_shd[r_wix + 3'd1];
            r_eof <= (r_wix == 3'd4);
          end
        end
        StClr: begin
          if (r_clr_cnt == CntW'(CLR_DEPTH - 1)) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_clr   <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sc_ctrl_pkt_d    = r_d;
  assign sc_ctrl_pkt_dval = r_dval;
  assign sc_ctrl_pkt_eof  = r_eof;
  assign scram_clr        = r_clr;
  assign busy             = r_busy;
  assign cmd_err          = r_cmd_err;
  assign pkt_cnt          = r_pkt_cnt;

endmodule

// File: tb/tb_scram_ctrl_pkt_gen.sv
// Bench for scram_ctrl_pkt_gen: queue-based expected-output model checked every cycle,
// plus literal expectations for packet contents, sweep length, cmd_err and pkt_cnt.
module tb_scram_ctrl_pkt_gen;
  localparam int ClrDepth = 64;

  logic        clk = 1'b0;
  logic        rst, cpu_wr;
  logic [2:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] sc_ctrl_pkt_d, pkt_cnt;
  logic        sc_ctrl_pkt_dval, sc_ctrl_pkt_eof, scram_clr, busy, cmd_err;

  always #5 clk = ~clk;

  scram_ctrl_pkt_gen #(.U_DLY(1), .CLR_DEPTH(ClrDepth)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_wr           (cpu_wr),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .sc_ctrl_pkt_d    (sc_ctrl_pkt_d),
    .sc_ctrl_pkt_dval (sc_ctrl_pkt_dval),
    .sc_ctrl_pkt_eof  (sc_ctrl_pkt_eof),
    .scram_clr        (scram_clr),
    .busy             (busy),
    .cmd_err          (cmd_err),
    .pkt_cnt          (pkt_cnt)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        dval;
    logic        eof;
    logic        clr;
    logic        busy;
  } exp_t;

  // Each queue entry is what the outputs must show in one future cycle; empty means idle.
  exp_t        q[$];
  logic [15:0] stg [6];
  logic [15:0] m_cnt;
  logic        m_err;
  bit          m_valid = 1'b0;
  int          n_vec = 0, n_err = 0;
  logic [15:0] cap[$];
  int          clr_seen = 0, busy_seen = 0, eof_seen = 0;
  logic [15:0] lit [6];

  function automatic exp_t mk(logic [15:0] d, logic v, logic e, logic c, logic b);
    exp_t x;
    x.d = d; x.dval = v; x.eof = e; x.clr = c; x.busy = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    chk("dval",    {31'b0, sc_ctrl_pkt_dval}, {31'b0, e.dval});
    chk("data",    {16'b0, sc_ctrl_pkt_d},    {16'b0, e.d});
    chk("eof",     {31'b0, sc_ctrl_pkt_eof},  {31'b0, e.eof});
    chk("clr",     {31'b0, scram_clr},        {31'b0, e.clr});
    chk("busy",    {31'b0, busy},             {31'b0, e.busy});
    chk("pkt_cnt", {16'b0, pkt_cnt},          {16'b0, m_cnt});
    chk("cmd_err", {31'b0, cmd_err},          {31'b0, m_err});
    if (sc_ctrl_pkt_dval === 1'b1) cap.push_back(sc_ctrl_pkt_d);
    if (scram_clr === 1'b1) clr_seen++;
    if (busy === 1'b1) busy_seen++;
    if (sc_ctrl_pkt_eof === 1'b1) eof_seen++;
  endtask

  task automatic push_clr();
    for (int k = 0; k < ClrDepth; k++) q.push_back(mk(16'h0, 1'b0, 1'b0, 1'b1, 1'b1));
  endtask

  // One clock: check current outputs, apply inputs, advance the model to the next cycle.
  task automatic cycle(input logic r, input logic w, input logic [2:0] a, input logic [15:0] dat);
    exp_t cur;
    bit   acc, eset;
    if (m_valid) check_outputs();
    cur = '0;
    if (q.size() > 0) cur = q.pop_front();
    if (cur.eof) m_cnt = m_cnt + 16'd1;
    acc = !cur.busy && (q.size() == 0);
    rst = r; cpu_wr = w; cpu_addr = a; cpu_wdata = dat;
    eset = 1'b0;
    if (r) begin
      q.delete();
      m_cnt = '0;
      m_err = 1'b0;
      for (int k = 0; k < 6; k++) stg[k] = '0;
      m_valid = 1'b1;
`ifdef SCRAM_CLR_ON_RST_EN
      q.push_back('0);
      push_clr();
`endif
    end else if (w) begin
      if (a == 3'd0) stg[0] = {10'b0, dat[5:0]};
      else if (a <= 3'd5) stg[a] = dat;
      else if (a == 3'd6) begin
        if (acc) begin
          if (dat[1]) begin
            push_clr();
            eset = dat[0];
          end else if (dat[0]) begin
            for (int k = 0; k < 6; k++) q.push_back(mk(stg[k], 1'b1, (k == 5), 1'b0, 1'b1));
          end
        end else begin
          eset = dat[0] | dat[1];
        end
        if (dat[2]) m_err = 1'b0;
        else if (eset) m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic after_reset();
`ifdef SCRAM_CLR_ON_RST_EN
    clr_seen = 0;
    idle(ClrDepth + 3);
    chk("auto_sweep_len", clr_seen, ClrDepth);
`else
    idle(2);
`endif
  endtask

  task automatic check_packet(input string name);
    chk({name, "_words"}, cap.size(), 6);
    if (cap.size() == 6)
      for (int i = 0; i < 6; i++) chk({name, "_word"}, {16'b0, cap[i]}, {16'b0, lit[i]});
  endtask

  initial begin
    lit = '{16'h0005, 16'hC123, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rst = 1'b1; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 3'd0, 16'h0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0);
    after_reset();
    chk("reset_pkt_cnt", {16'b0, pkt_cnt}, 0);
    chk("reset_busy", {31'b0, busy}, 0);

    // Basic packet
    wr(3'd0, 16'h0005); wr(3'd1, 16'hC123);
    wr(3'd2, 16'h1111); wr(3'd3, 16'h2222); wr(3'd4, 16'h3333); wr(3'd5, 16'h4444);
    cap.delete(); eof_seen = 0;
    wr(3'd6, 16'h0001);
    idle(8);
    check_packet("pkt1");
    chk("pkt1_eof_count", eof_seen, 1);
    chk("pkt1_pkt_cnt", {16'b0, pkt_cnt}, 1);

    // Clear sweep
    cap.delete(); clr_seen = 0; busy_seen = 0;
    wr(3'd6, 16'h0002);
    idle(ClrDepth + 4);
    chk("clr_len", clr_seen, ClrDepth);
    chk("clr_busy_len", busy_seen, ClrDepth);
    chk("clr_no_dval", cap.size(), 0);

    // Commit during SEND plus staging write in flight
    cap.delete();
    wr(3'd6, 16'h0001);
    idle(1);
    wr(3'd1, 16'hAAAA);
    wr(3'd6, 16'h0001);
    idle(8);
    check_packet("pkt2");
    chk("pkt2_pkt_cnt", {16'b0, pkt_cnt}, 2);
    chk("busy_commit_err", {31'b0, cmd_err}, 1);
    wr(3'd6, 16'h0004);
    idle(1);
    chk("err_clear", {31'b0, cmd_err}, 0);

    // Commit + clear together
    cap.delete(); clr_seen = 0;
    wr(3'd6, 16'h0003);
    idle(ClrDepth + 4);
    chk("cc_clr_len", clr_seen, ClrDepth);
    chk("cc_no_dval", cap.size(), 0);
    chk("cc_err", {31'b0, cmd_err}, 1);
    chk("cc_pkt_cnt", {16'b0, pkt_cnt}, 2);

    // Error clear wins over same-cycle rejected command
    wr(3'd6, 16'h0002);
    idle(2);
    wr(3'd6, 16'h0005);
    idle(1);
    chk("err_clr_priority", {31'b0, cmd_err}, 0);
    idle(ClrDepth);

    // Reset on word 3
    eof_seen = 0;
    wr(3'd6, 16'h0001);
    idle(3);
    cycle(1'b1, 1'b0, 3'd0, 16'h0);
    chk("rst_abort_dval", {31'b0, sc_ctrl_pkt_dval}, 0);
    after_reset();
    chk("rst_abort_eof", eof_seen, 0);
    chk("rst_abort_pkt_cnt", {16'b0, pkt_cnt}, 0);

    // Counter wrap: preload near 0xFFFF, then back-to-back commits
    force dut.r_pkt_cnt = 16'hFFFD;
    #2;
    release dut.r_pkt_cnt;
    m_cnt = 16'hFFFD;
    for (int p = 0; p < 5; p++) begin
      wr(3'd6, 16'h0001);
      idle(6);
      if (p == 2) chk("wrap_zero", {16'b0, pkt_cnt}, 0);
    end
    idle(2);
    chk("wrap_final", {16'b0, pkt_cnt}, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scram_ctrl_pkt_gen.md
SCRAM_CTRL_PKT_GEN -- requirements
Module: scram_ctrl_pkt_gen

Interface
REQ-001 SHALL have parameter U_DLY, default 1, simulation-only register assignment delay with no functional effect.
REQ-002 SHALL have parameter CLR_DEPTH, default 64, number of scram_clr cycles per clear sweep (PID table entries).
REQ-003 Ports, clock and reset first:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; synchronous, active-high.
- cpu_wr  in  1  host register write strobe, one cycle per write.
- cpu_addr  in  3  host register address.
- cpu_wdata  in  16  host write data.
- sc_ctrl_pkt_d  out  16  control packet word.
- sc_ctrl_pkt_dval  out  1  packet word valid.
- sc_ctrl_pkt_eof  out  1  last word of packet, coincident with its dval.
- scram_clr  out  1  PID-table clear strobe, held for a sweep.
- busy  out  1  packet send or clear sweep in progress.
- cmd_err  out  1  sticky: command rejected.
- pkt_cnt  out  16  packets sent since reset, wraps.

Function
REQ-004 Staging registers by cpu_addr: 0 index[5:0]; 1 pid word {en, parity, rsvd, pid[12:0]}; 2..5 cw[63:48], cw[47:32], cw[31:16], cw[15:0]; 6 command; 7 ignored.
REQ-005 Staging registers SHALL be writable at any time, including while busy, without affecting a packet already in flight.
REQ-006 Command bits: bit0 commit, bit1 clear, bit2 cmd_err clear. Other bits are ignored.
REQ-007 FSM states: IDLE, SEND, CLR. busy SHALL be 1 exactly when the state is not IDLE.
REQ-008 IDLE, commit only:
- copy the six staging words into a shadow buffer in the write cycle;
- enter SEND on the next cycle.
REQ-009 SEND SHALL output six words on consecutive cycles with dval=1 and no gaps:
- word 0 = {10'b0, index}; word 1 = pid word; words 2..5 = cw high to low;
- eof=1 only with word 5;
- first dval in the cycle after the commit write.
REQ-010 After word 5: pkt_cnt SHALL increment by 1 (0xFFFF wraps to 0x0000) and the FSM SHALL return to IDLE. A new commit is accepted in the next cycle.
REQ-011 IDLE, clear bit set:
- enter CLR and assert scram_clr for exactly CLR_DEPTH consecutive cycles, starting the cycle after the write;
- return to IDLE after the last cycle;
- dval SHALL stay 0 throughout.
REQ-012 Commit and clear written together SHALL run the clear, drop the commit, and set cmd_err.
REQ-013 A commit or clear written while busy SHALL be ignored, set cmd_err, and leave the current operation unchanged.
REQ-014 cmd_err clear (bit2) SHALL take priority over a same-cycle error set.
REQ-015 When dval=0: sc_ctrl_pkt_d SHALL be 0 and eof SHALL be 0.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 rst=1 SHALL force:
- state IDLE, busy=0;
- sc_ctrl_pkt_d=0, dval=0, eof=0, scram_clr=0;
- cmd_err=0, pkt_cnt=0;
- staging and shadow registers to 0.
REQ-018 rst during SEND SHALL abort the packet with no eof emitted. rst during CLR SHALL end the sweep. Outputs SHALL show reset values in the cycle after rst is sampled.

Configuration
REQ-019 Macro SCRAM_CLR_ON_RST_EN:
- defined: after rst deasserts, the FSM SHALL enter CLR automatically and run one full sweep before accepting commands; commands during the sweep are rejected per REQ-013;
- undefined: the FSM SHALL stay in IDLE after reset until a command is written.

Verification
REQ-020 Bench SHALL cover:
- Write idx=5, pid=0xC123, cw=0x1111/2222/3333/4444, then commit -> dval words 0x0005, 0xC123, 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; eof only on 0x4444; pkt_cnt=1.
- Clear command -> scram_clr high for exactly 64 cycles, busy high over the same window, dval=0 throughout.
- Commit during SEND -> current packet completes unchanged, only one packet sent, cmd_err=1; then write 0x0004 to command -> cmd_err=0.
- Command value 0x0003 in IDLE -> 64-cycle clear, no packet, cmd_err=1.
- rst asserted on word 3 -> next cycle dval=0, eof never seen, pkt_cnt=0; with SCRAM_CLR_ON_RST_EN defined, a 64-cycle sweep follows reset release.
- 65536 back-to-back commits -> pkt_cnt wraps to 0x0000.
